// File: rtl/m21_select_arbiter.sv
// Round-robin arbiter for the two sources of the m21 2:1 mux.
// Registered one-hot grant plus mux select; grants persist until release or hold-limit preemption.
module m21_select_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    output logic [1:0] gnt,
    output logic       select,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [1:0]    gnt_nxt;
    logic          select_nxt;
    logic          busy_nxt;

    logic          owner;
    logic          pick_from;
    logic          pick_vld;
    logic          pick_idx;
    logic          rel;
    logic          pre;

    // pick() priority base is `last` in IDLE and the current owner in a grant state,
    // since a release/preempt makes the owner the new `last` on the same edge.
    always_comb begin
        owner     = (state == GNT1);
        pick_from = (state == IDLE) ? last : owner;
        pick_vld  = |req;
        pick_idx  = req[~pick_from] ? ~pick_from : pick_from;
        rel       = done | ~req[owner];
        pre       = (hold_cnt == HOLD_LAST) & req[~owner];
    end

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt    = pick_idx ? GNT1 : GNT0;
                    hold_cnt_nxt = '0;
                end
            end
            GNT0, GNT1: begin
                if (rel | pre) begin
                    last_nxt = owner;
                    if (pick_vld) begin
                        state_nxt    = pick_idx ? GNT1 : GNT0;
                        hold_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_comb begin
        gnt_nxt    = 2'b00;
        select_nxt = select;
        busy_nxt   = 1'b0;
        case (state_nxt)
            GNT0: begin
                gnt_nxt    = 2'b01;
                select_nxt = 1'b0;
                busy_nxt   = 1'b1;
            end
            GNT1: begin
                gnt_nxt    = 2'b10;
                select_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
            default: begin
                gnt_nxt  = 2'b00;
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            gnt      <= 2'b00;
            select   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            select   <= select_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
